// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU: opcode and FSM enums,
// flag bit positions and a small opcode classifier.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        AND = 3'd1,
        OR  = 3'd2,
        SUB = 3'd3,
        XOR = 3'd4,
        SHL = 3'd5,
        SHR = 3'd6,
        SAR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } alu_state_e;

    localparam int C_IDX = 0;
    localparam int Z_IDX = 1;
    localparam int N_IDX = 2;

    function automatic logic is_shift(input alu_op_e op);
        return (op == SHL) || (op == SHR) || (op == SAR);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath with flag generation. For shift opcodes it
// performs a one-position step; the multi-cycle sequencing lives in alu_mc.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       czn
);

    logic [WIDTH:0] sum;
    logic           carry;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (alu_op_e'(op))
            ADD: begin
                sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            // c_in = 1 means no borrow-in; carry out = 1 means no borrow.
            SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, c_in};
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OR:  result = a | b;
            XOR: result = a ^ b;
            SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            SAR: begin
                result = {a[WIDTH-1], a[WIDTH-1:1]};
                carry  = a[0];
            end
            default: result = a & b;
        endcase
    end

    always_comb begin
        czn        = '0;
        czn[C_IDX] = carry;
        czn[Z_IDX] = ~|result;
        czn[N_IDX] = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic ops, bit-serial shifts, and a
// valid/ready handshake on both the request and result sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       czn
);

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    alu_state_e       state_q, state_d;
    alu_op_e          op_q, op_in;
    logic [2:0]       op_sel;
    logic             live_q;
    logic [SHW-1:0]   cnt_q, amt;
    logic [WIDTH-1:0] result_q, operand, alu_res;
    logic [2:0]       czn_q, alu_czn, pass_czn;
    logic             accept, shift_in, start_shift;

    assign op_in       = alu_op_e'(opcode);
    assign amt         = b[SHW-1:0];
    assign shift_in    = is_shift(op_in);
    assign start_shift = shift_in && (amt != '0);

    // live_q holds in_ready low until the first edge after reset release.
    assign in_ready  = live_q && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign result    = result_q;
    assign czn       = czn_q;

    // While shifting, the result register doubles as the shifter and the
    // combinational block supplies one bit step per cycle.
    assign op_sel  = (state_q == SHIFT) ? op_q : op_in;
    assign operand = (state_q == SHIFT) ? result_q : a;

    alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .op     (op_sel),
        .a      (operand),
        .b      (b),
        .c_in   (c_in),
        .result (alu_res),
        .czn    (alu_czn)
    );

    // Zero-amount shift passes a through with carry taken from c_in.
    always_comb begin
        pass_czn        = '0;
        pass_czn[C_IDX] = c_in;
        pass_czn[Z_IDX] = ~|a;
        pass_czn[N_IDX] = a[WIDTH-1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = start_shift ? SHIFT : HOLD;
                end
            end
            SHIFT: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = start_shift ? SHIFT : HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            op_q     <= ADD;
            cnt_q    <= '0;
            result_q <= '0;
            czn_q    <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (accept) begin
                op_q <= op_in;
                if (start_shift) begin
                    cnt_q    <= amt;
                    result_q <= a;
                    czn_q    <= '0;
                end else if (shift_in) begin
                    cnt_q    <= '0;
                    result_q <= a;
                    czn_q    <= pass_czn;
                end else begin
                    cnt_q    <= '0;
                    result_q <= alu_res;
                    czn_q    <= alu_czn;
                end
            end else if (state_q == SHIFT) begin
                result_q <= alu_res;
                czn_q    <= alu_czn;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): transaction-level reference model,
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_alu_mc;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SAR = 3'd7;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic       c_in      = 1'b0;
    logic [2:0] opcode    = '0;
    logic [7:0] a         = '0;
    logic [7:0] b         = '0;
    logic       in_ready, out_valid;
    logic [7:0] result;
    logic [2:0] czn;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_mc #(
        .WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .czn       (czn)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {N, Z, C, result} for a whole operation, straight from the op definitions.
    function automatic logic [10:0] model_op(input logic [2:0] op, input logic [7:0] x,
                                             input logic [7:0] y, input logic ci);
        int         k;
        int         s;
        logic [7:0] r;
        logic       c;
        k = int'(y[2:0]);
        s = 0;
        c = 1'b0;
        case (op)
            3'd0: begin s = int'(x) + int'(y) + int'(ci);         r = 8'(s); c = s >= 256; end
            3'd3: begin s = int'(x) + (255 - int'(y)) + int'(ci); r = 8'(s); c = s >= 256; end
            3'd2: r = x | y;
            3'd4: r = x ^ y;
            3'd5: begin r = 8'(x << k);            c = (k == 0) ? ci : x[8-k]; end
            3'd6: begin r = x >> k;                c = (k == 0) ? ci : x[k-1]; end
            3'd7: begin r = 8'($signed(x) >>> k);  c = (k == 0) ? ci : x[k-1]; end
            default: r = x & y;
        endcase
        return {r[7], (r == 8'h00), c, r};
    endfunction

    // Extra cycles beyond the single-cycle latency.
    function automatic int model_lat(input logic [2:0] op, input logic [7:0] y);
        return (op >= 3'd5) ? int'(y[2:0]) : 0;
    endfunction

    logic       m_live, m_valid, m_ready;
    int         m_wait;
    logic [7:0] m_res;
    logic [2:0] m_czn;

    assign m_ready = m_live && ((!m_valid && m_wait == 0) || (m_valid && out_ready));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live  <= 1'b0;
            m_valid <= 1'b0;
            m_wait  <= 0;
            m_res   <= '0;
            m_czn   <= '0;
        end else begin
            m_live <= 1'b1;
            if (in_valid && m_ready) begin
                {m_czn, m_res} <= model_op(opcode, a, b, c_in);
                m_wait         <= model_lat(opcode, b);
                m_valid        <= (model_lat(opcode, b) == 0);
            end else if (m_wait > 0) begin
                m_wait  <= m_wait - 1;
                m_valid <= (m_wait == 1);
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_result", result, 0);
            check("rst_czn", czn, 0);
        end else begin
            check("in_ready", in_ready, m_ready);
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("result", result, m_res);
                check("czn", czn, m_czn);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y, input logic ci);
        int n;
        n        = 0;
        in_valid = 1'b1;
        opcode   = op;
        a        = x;
        b        = y;
        c_in     = ci;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("send_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output int busy);
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("valid_seen", out_valid, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, busy;

        check("pin_add", model_op(OP_ADD, 8'hFF, 8'h01, 1'b0), {3'b011, 8'h00});
        check("pin_sub", model_op(OP_SUB, 8'h05, 8'h07, 1'b1), {3'b100, 8'hFE});
        check("pin_shl", model_op(OP_SHL, 8'h81, 8'h03, 1'b0), {3'b000, 8'h08});
        check("pin_sar", model_op(OP_SAR, 8'h80, 8'h07, 1'b0), {3'b100, 8'hFF});
        check("pin_shr", model_op(OP_SHR, 8'h01, 8'h01, 1'b0), {3'b011, 8'h00});
        check("pin_lat", model_lat(OP_SHL, 8'h03), 3);

        #1 rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("ready_pre_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("ready_post_edge", in_ready, 1);

        send(OP_ADD, 8'hFF, 8'h01, 1'b0);
        check("add_valid", out_valid, 1);
        check("add_result", result, 8'h00);
        check("add_czn", czn, 3'b011);
        @(posedge clk); #1;

        send(OP_SUB, 8'h05, 8'h07, 1'b1);
        check("sub_result", result, 8'hFE);
        check("sub_czn", czn, 3'b100);
        @(posedge clk); #1;

        send(OP_SHL, 8'h81, 8'h03, 1'b0);
        wait_valid(lat, busy);
        check("shl_lat", lat, 4);
        check("shl_busy", busy, 3);
        check("shl_result", result, 8'h08);
        check("shl_czn", czn, 3'b000);
        @(posedge clk); #1;

        send(OP_SAR, 8'h80, 8'h07, 1'b0);
        wait_valid(lat, busy);
        check("sar_lat", lat, 8);
        check("sar_result", result, 8'hFF);
        check("sar_czn", czn, 3'b100);
        @(posedge clk); #1;

        send(OP_SHR, 8'h01, 8'h01, 1'b0);
        wait_valid(lat, busy);
        check("shr_lat", lat, 2);
        check("shr_result", result, 8'h00);
        check("shr_czn", czn, 3'b011);
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(OP_XOR, 8'h3C, 8'h0F, 1'b0);
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_result", result, 8'h33);
            check("hold_czn", czn, 3'b000);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send(OP_AND, 8'h0F, 8'hF0, 1'b0);
        check("b2b_valid", out_valid, 1);
        check("b2b_result", result, 8'h00);
        check("b2b_czn", czn, 3'b010);
        @(posedge clk); #1;

        send(OP_SHL, 8'h81, 8'h07, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_czn", czn, 0);
        check("abort_in_ready", in_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("release_ready", in_ready, 0);
        check("release_valid", out_valid, 0);
        @(posedge clk); #1;
        check("release_ready_edge", in_ready, 1);
        send(OP_ADD, 8'h01, 8'h01, 1'b0);
        check("post_rst_result", result, 8'h02);
        check("post_rst_czn", czn, 3'b000);
        @(posedge clk); #1;

        for (int unsigned i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            opcode    = 3'($urandom_range(0, 7));
            a         = 8'($urandom);
            b         = 8'($urandom);
            c_in      = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
